// File: rtl/disp_pkg.sv
// Shared constants for the seven-segment display path.
package disp_pkg;
    localparam int unsigned DISP_DIGITS = 4;
    localparam logic [3:0]  AN_OFF      = 4'b1111;
    localparam logic        DP_OFF      = 1'b1;
endpackage

// File: rtl/disp_scan_ctrl_tick_gen.sv
// Digit-slot prescaler: counts 0..DIV_CNT-1 and flags the last count.
module tick_gen #(
    parameter int unsigned DIV_CNT = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned  W    = $clog2(DIV_CNT);
    localparam logic [W-1:0] LAST = W'(DIV_CNT - 1);

    logic [W-1:0] pcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (pcnt == LAST)
            pcnt <= '0;
        else
            pcnt <= pcnt + 1'b1;
    end

    assign tick = (pcnt == LAST);
endmodule

// File: rtl/disp_scan_ctrl.sv
// Four-digit seven-segment scan controller with shadowed data and registered outputs.
// Optional leading-zero suppression when DISP_LZ_BLANK_EN is defined.
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned DIV_CNT = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] data,
    input  logic [3:0]  dp_in,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        dp,
    output logic        blank
);
    localparam int unsigned IW = $clog2(DISP_DIGITS);

    logic          tick;
    logic [IW-1:0] idx;
    logic [15:0]   sh_data;
    logic [3:0]    sh_dp;
    logic [3:0]    an_nxt;
    logic [3:0]    digit_nxt;
    logic          dp_nxt;
    logic          blank_nxt;

    tick_gen #(.DIV_CNT(DIV_CNT)) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Next-slot outputs come from the pre-edge shadow, so a load coinciding with a tick shows next time round.
    always_comb begin
        an_nxt    = ~(4'b0001 << idx);
        digit_nxt = sh_data[{idx, 2'b00} +: 4];
        dp_nxt    = ~sh_dp[idx];
        blank_nxt = 1'b0;
`ifdef DISP_LZ_BLANK_EN
        unique case (idx)
            2'd1:    blank_nxt = (sh_data[15:4]  == '0);
            2'd2:    blank_nxt = (sh_data[15:8]  == '0);
            2'd3:    blank_nxt = (sh_data[15:12] == '0);
            default: blank_nxt = 1'b0;
        endcase
        if (blank_nxt) begin
            an_nxt    = AN_OFF;
            digit_nxt = '0;
            dp_nxt    = DP_OFF;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= '0;
            sh_data <= '0;
            sh_dp   <= '0;
            an      <= AN_OFF;
            digit   <= '0;
            dp      <= DP_OFF;
            blank   <= 1'b0;
        end else begin
            if (load) begin
                sh_data <= data;
                sh_dp   <= dp_in;
            end
            if (tick) begin
                idx   <= idx + 1'b1;
                an    <= an_nxt;
                digit <= digit_nxt;
                dp    <= dp_nxt;
                blank <= blank_nxt;
            end
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Self-checking bench for disp_scan_ctrl (DIV_CNT = 4); honours DISP_LZ_BLANK_EN.
module tb_disp_scan_ctrl;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        dp;
    logic        blank;

    int n_pass = 0;
    int n_total = 0;

    disp_scan_ctrl #(.DIV_CNT(DIV)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .data  (data),
        .dp_in (dp_in),
        .an    (an),
        .digit (digit),
        .dp    (dp),
        .blank (blank)
    );

    always #5 clk = ~clk;

    // Behavioural model: edge count since reset decides tick edges and the slot shown.
    int          e = 0;
    bit          m_valid = 0;
    logic [15:0] m_sd = '0;
    logic [3:0]  m_sdp = '0;
    logic [3:0]  m_an = 4'b1111;
    logic [3:0]  m_digit = '0;
    logic        m_dp = 1'b1;
    logic        m_blank = 1'b0;

    always @(posedge clk or posedge rst) begin
        logic [15:0] old_sd;
        logic [3:0]  old_dp;
        int          k;
        bit          lz;
        if (rst) begin
            e = 0; m_valid = 1;
            m_sd = '0; m_sdp = '0;
            m_an = 4'b1111; m_digit = '0; m_dp = 1'b1; m_blank = 1'b0;
        end else begin
            e++;
            old_sd = m_sd;
            old_dp = m_sdp;
            if (load) begin
                m_sd = data;
                m_sdp = dp_in;
            end
            if (e % DIV == 0) begin
                k = (e / DIV - 1) % 4;
                lz = 0;
`ifdef DISP_LZ_BLANK_EN
                lz = (k > 0) && ((old_sd >> (4 * k)) == 16'h0);
`endif
                if (lz) begin
                    m_an = 4'b1111; m_digit = 4'h0; m_dp = 1'b1; m_blank = 1'b1;
                end else begin
                    m_an = 4'b1111 & ~(4'(1) << k);
                    m_digit = 4'((old_sd >> (4 * k)) & 16'hF);
                    m_dp = ~old_dp[k];
                    m_blank = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    endtask

    // Compare every cycle, away from the active edge.
    always @(posedge clk) begin
        #2;
        if (!rst && m_valid) begin
            check("an", 16'(an), 16'(m_an));
            check("digit", 16'(digit), 16'(m_digit));
            check("dp", 16'(dp), 16'(m_dp));
            check("blank", 16'(blank), 16'(m_blank));
        end
    end

    task automatic go_mod16(input int r);
        for (int i = 0; i < 17; i++) begin
            @(posedge clk); #2;
            if (e % 16 == r) return;
        end
        check("align_timeout", 16'd1, 16'd0);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk); data = d; dp_in = p; load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an", 16'(an), 16'h000F);
        check("rst_dp", 16'(dp), 16'h0001);
        check("rst_digit", 16'(digit), 16'h0000);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 check("pre_tick_an", 16'(an), 16'h000F);
        @(posedge clk); #2;
        check("first_tick_an", 16'(an), 16'h000E);
        check("first_tick_digit", 16'(digit), 16'h0000);

        // Scan order
        do_load(16'h1234, 4'b0100);
        go_mod16(4);
        check("scan0_an", 16'(an), 16'h000E); check("scan0_dig", 16'(digit), 16'h4); check("scan0_dp", 16'(dp), 16'h1);
        go_mod16(8);
        check("scan1_an", 16'(an), 16'h000D); check("scan1_dig", 16'(digit), 16'h3); check("scan1_dp", 16'(dp), 16'h1);
        go_mod16(12);
        check("scan2_an", 16'(an), 16'h000B); check("scan2_dig", 16'(digit), 16'h2); check("scan2_dp", 16'(dp), 16'h0);
        go_mod16(0);
        check("scan3_an", 16'(an), 16'h0007); check("scan3_dig", 16'(digit), 16'h1); check("scan3_dp", 16'(dp), 16'h1);

        // Load coinciding with the idx-1 tick
        go_mod16(7);
        @(negedge clk); data = 16'hABCD; dp_in = 4'b0000; load = 1'b1;
        @(posedge clk); #2;
        check("loadtick_old", 16'(digit), 16'h3);
        @(negedge clk); load = 1'b0;
        go_mod16(8);
        check("loadtick_new", 16'(digit), 16'hC);

        // Async reset mid-scan
        go_mod16(13);
        check("pre_arst_an", 16'(an), 16'h000B);
        #1 rst = 1'b1;
        #1;
        check("arst_an", 16'(an), 16'h000F);
        check("arst_digit", 16'(digit), 16'h0);
        check("arst_dp", 16'(dp), 16'h1);
        check("arst_blank", 16'(blank), 16'h0);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #2 check("restart_an", 16'(an), 16'h000E);

        // Leading-zero cases
        do_load(16'h0050, 4'b1111);
        go_mod16(0);
`ifdef DISP_LZ_BLANK_EN
        check("lz3_an", 16'(an), 16'h000F); check("lz3_blank", 16'(blank), 16'h1);
        go_mod16(4);
        check("lz0_an", 16'(an), 16'h000E); check("lz0_dig", 16'(digit), 16'h0); check("lz0_blank", 16'(blank), 16'h0);
        go_mod16(8);
        check("lz1_dig", 16'(digit), 16'h5); check("lz1_blank", 16'(blank), 16'h0);
        go_mod16(12);
        check("lz2_an", 16'(an), 16'h000F); check("lz2_blank", 16'(blank), 16'h1); check("lz2_dp", 16'(dp), 16'h1);
`else
        check("nolz3_an", 16'(an), 16'h0007); check("nolz3_blank", 16'(blank), 16'h0);
        go_mod16(12);
        check("nolz2_an", 16'(an), 16'h000B); check("nolz2_dp", 16'(dp), 16'h0);
`endif
        do_load(16'h0000, 4'b0000);
        go_mod16(0);
`ifdef DISP_LZ_BLANK_EN
        check("zero3_an", 16'(an), 16'h000F);
`else
        check("zero3_an", 16'(an), 16'h0007); check("zero3_blank", 16'(blank), 16'h0);
`endif
        go_mod16(4);
        check("zero0_an", 16'(an), 16'h000E); check("zero0_dig", 16'(digit), 16'h0);

        // Randomized loads, including values with leading zeros
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            load = ($urandom_range(0, 5) == 0);
            data = 16'($urandom >> $urandom_range(16, 31));
            dp_in = 4'($urandom);
            if (i == 250) begin
                #2 rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
        end
        @(negedge clk); load = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/disp_scan_ctrl.md
# disp_scan_ctrl

Time-multiplexed scan controller for the 4-digit seven-segment display. It snapshots a 16-bit hex value, rotates a one-cold anode enable across four digits at a prescaled rate, and presents the matching 4-bit nibble to the downstream 4-bit 2:1 / hex-decode path. The block is the upstream stage that feeds the display mux. It owns all sequencing, so that downstream logic stays purely combinational.

## Interface
- DIV_CNT, 100000: clock cycles per digit slot; legal range is DIV_CNT ≥ 2, and the default gives 1 kHz per digit at 100 MHz.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  when high on a clock edge, `data` and `dp_in` are captured into shadow registers.
- data  in  16  hex value to display; digit k is `data[4k+3:4k]`, and digit 0 is rightmost.
- dp_in  in  4  decimal-point request per digit, active-high.
- an  out  4  anode enables, active-low, one-cold.
- digit  out  4  nibble for the currently enabled digit.
- dp  out  1  decimal point for the current digit, active-low.
- blank  out  1  high while the current slot is suppressed.

## Operation
- Shadow registers `sh_data[15:0]` and `sh_dp[3:0]` load on `load`. They hold their value otherwise.
- Prescaler `pcnt` has width `$clog2(DIV_CNT)`.
  - It counts 0 .. DIV_CNT-1 and then wraps to 0.
  - `tick` = (`pcnt` == DIV_CNT-1), combinational.
- Scan index `idx[1:0]` advances 0→1→2→3→0 on each tick.
- On a tick edge, the output registers are written for the current `idx` using pre-edge shadow values:
  - `an` = ~(4'b0001 << idx)
  - `digit` = `sh_data[4*idx +: 4]`
  - `dp` = ~`sh_dp[idx]`
  - `blank` = 0
- Between ticks, all outputs hold.
- Simultaneous `load` and tick: the tick uses the old shadow contents. The new value first appears at the next tick.
- Reset, at any time including mid-scan, forces the following immediately:
  - `pcnt` = 0, `idx` = 0
  - `sh_data` = 0, `sh_dp` = 0
  - `an` = 4'b1111, `digit` = 0, `dp` = 1, `blank` = 0

## Timing
- After `rst` is released, the first tick edge is the DIV_CNT-th rising clk edge. It drives digit 0, giving `an` = 4'b1110.
- Outputs change only on tick edges, exactly DIV_CNT cycles apart.
- A full refresh takes 4·DIV_CNT cycles.
- Load-to-visible latency is at most 4·DIV_CNT cycles. For a given digit, the value shows on the first tick of that digit strictly after the load edge.
- `an`, `digit`, `dp` and `blank` are all registered and update on the same edge. No cycle exists where they are misaligned.

## Configuration
- `DISP_LZ_BLANK_EN` defined: leading-zero suppression is enabled.
  - On a tick for slot k in 1..3: if `sh_data[15:4k]` == 0, then `an` = 4'b1111, `blank` = 1, `dp` = 1 (point off), and `digit` = 0.
  - Digit 0 is never blanked.
- `DISP_LZ_BLANK_EN` undefined: `blank` is a constant 0 and every slot is always enabled.

## Structure
- Shared package `disp_pkg` holds:
  - `DISP_DIGITS` = 4
  - `AN_OFF` = 4'b1111
  - `DP_OFF` = 1'b1
- Sub-module `tick_gen`: parameter DIV_CNT; inputs `clk`, `rst`; output `tick`. It contains the prescaler only.
- The scan index, shadow registers and output registers stay in the top level.

## Test plan
All scenarios use DIV_CNT = 4.
- **Reset state:** assert `rst` for 3 cycles, then release. Check `an` = 1111, `dp` = 1, `digit` = 0. On the 4th edge, `an` = 1110 and `digit` = 0.
- **Scan order:** load `data` = 16'h1234, `dp_in` = 4'b0100. Over 16 cycles, check `an` steps 1110, 1101, 1011, 0111 with `digit` 4, 3, 2, 1. `dp` = 0 only while `an` = 1011.
- **Load on tick:** with `data` = 16'hABCD, pulse `load` on the same edge as the tick for idx 1. That slot shows the old digit. The next idx-1 slot shows C.
- **Async reset mid-scan:** assert `rst` between clock edges while `an` = 1011. Outputs go to reset values before the next edge, and the scan restarts at digit 0.
- **With `DISP_LZ_BLANK_EN`, `data` = 16'h0050:**
  - Slots 3 and 2 give `an` = 1111, `blank` = 1.
  - Slot 1 shows 5.
  - Slot 0 shows 0, unblanked.
- **With `DISP_LZ_BLANK_EN`, `data` = 16'h0000:** only digit 0 is enabled, showing 0. Without the macro, all four slots show 0 and `blank` stays 0.
